// File: rtl/dica_pkg.sv
// Shared types and constants for the DMEM dirty-block tracker.
// Holds the FSM state enum, default geometry constants and block-index helpers.
package dica_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SCAN  = 2'd2
    } state_t;

    localparam int DMEM_SIZE_D = 2048;
    localparam int BLK_SIZE_D  = 128;

    // Index width never collapses to zero, even for a single block.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NBLK   = DMEM_SIZE_D / BLK_SIZE_D;
    localparam int IDX_W  = idx_width(NBLK);
    localparam int BLK_SH = $clog2(BLK_SIZE_D);

    // Block number of a byte address relative to the DMEM base.
    function automatic logic [15:0] blk_idx(
        input logic [15:0] addr,
        input logic [15:0] base,
        input int          sh
    );
        logic [15:0] off;
        off = addr - base;
        return off >> sh;
    endfunction

endpackage

// File: rtl/dica_ffs.sv
// Find-first-set over N bits: valid=|vec, idx=lowest set bit position.
// Ports: vec (in, N), valid (out, 1), idx (out, IW; 0 when vec is empty).
module dica_ffs #(
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  logic [N-1:0]  vec,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        idx = '0;
        // Scan downward so the lowest set bit is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end

    assign valid = |vec;

endmodule

// File: rtl/dirty_block_tracker.sv
// Dirty-block tracker and checkpoint sequencer for openMSP430 DMEM.
// Optional dead-stack filtering is enabled by defining DICA_STACK_FILTER_EN.
// Ports: clk, reset_n (sync, active-high), data_addr/data_wr (write snoop),
//   sp, lambda, v_supply (threshold inputs), ckpt_ack, scan_req, scan_pop,
//   irq_chkpnt, scan_valid, scan_idx, scan_done, dirty_cnt, dirty_tbl.
module dirty_block_tracker
    import dica_pkg::*;
#(
    parameter logic [15:0] DMEM_BASE = 16'h0200,
    parameter int          DMEM_SIZE = DMEM_SIZE_D,
    parameter int          BLK_SIZE  = BLK_SIZE_D,
    parameter logic [15:0] SP_LIM    = 16'h0600,
    parameter int          LAMBDA_W  = 16,
    parameter int          V_W       = 32,
    localparam int NB = DMEM_SIZE / BLK_SIZE,
    localparam int IW = idx_width(NB),
    localparam int SH = $clog2(BLK_SIZE)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [15:0]         data_addr,
    input  logic                data_wr,
    input  logic [15:0]         sp,
    input  logic [LAMBDA_W-1:0] lambda,
    input  logic [V_W-1:0]      v_supply,
    input  logic                ckpt_ack,
    input  logic                scan_req,
    input  logic                scan_pop,
    output logic                irq_chkpnt,
    output logic                scan_valid,
    output logic [IW-1:0]       scan_idx,
    output logic                scan_done,
    output logic [IW:0]         dirty_cnt,
    output logic [NB-1:0]       dirty_tbl
);

    localparam int TW = LAMBDA_W + IW + 1;
    localparam int CW = (TW > V_W) ? TW : V_W;

    state_t        state;
    state_t        state_nxt;
    logic [NB-1:0] set_mask;
    logic [NB-1:0] pop_mask;
    logic [NB-1:0] filt_mask;
    logic [NB-1:0] tbl_nxt;
    logic [IW:0]   cnt_nxt;
    logic          ffs_valid;
    logic [IW-1:0] ffs_idx;
    logic [16:0]   wr_off;
    logic          wr_hit;
    logic [IW-1:0] wr_blk;
    logic [TW-1:0] v_th;
    logic          thr_hit;

    // 17-bit offset keeps the upper range bound free of 16-bit wrap.
    assign wr_off = {1'b0, data_addr} - {1'b0, DMEM_BASE};
    assign wr_hit = data_wr
                  && (data_addr >= DMEM_BASE)
                  && (wr_off < 17'(DMEM_SIZE));
    assign wr_blk = IW'(blk_idx(data_addr, DMEM_BASE, SH));

`ifdef DICA_STACK_FILTER_EN
    localparam int LIM_BLK = int'(blk_idx(SP_LIM, DMEM_BASE, SH));

    logic [16:0] sp_off;
    logic        sp_in;
    int          sp_blk;

    assign sp_off = {1'b0, sp} - {1'b0, DMEM_BASE};
    assign sp_in  = (sp >= DMEM_BASE) && (sp_off < 17'(DMEM_SIZE));
    assign sp_blk = int'(blk_idx(sp, DMEM_BASE, SH));

    // Blocks strictly between the stack limit and the live SP are dead.
    always_comb begin
        filt_mask = '0;
        for (int b = 0; b < NB; b++) begin
            if (sp_in && (b > LIM_BLK) && (b < sp_blk))
                filt_mask[b] = 1'b1;
        end
    end
`else
    logic sp_unused;
    assign sp_unused = ^sp;
    assign filt_mask = '0;
`endif

    always_comb begin
        set_mask = '0;
        pop_mask = '0;
        if (wr_hit)
            set_mask[wr_blk] = 1'b1;
        if (scan_valid && scan_pop)
            pop_mask[ffs_idx] = 1'b1;
    end

    // Set is applied last so a same-cycle write beats pop and filter.
    assign tbl_nxt = (dirty_tbl & ~pop_mask & ~filt_mask) | set_mask;

    always_comb begin
        cnt_nxt = '0;
        for (int b = 0; b < NB; b++) begin
            cnt_nxt = cnt_nxt + {{IW{1'b0}}, dirty_tbl[b]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            dirty_tbl <= '0;
            dirty_cnt <= '0;
        end else begin
            dirty_tbl <= tbl_nxt;
            dirty_cnt <= cnt_nxt;
        end
    end

    dica_ffs #(
        .N  (NB),
        .IW (IW)
    ) u_ffs (
        .vec   (dirty_tbl),
        .valid (ffs_valid),
        .idx   (ffs_idx)
    );

    assign v_th    = TW'(lambda) * TW'(dirty_cnt);
    assign thr_hit = (CW'(v_supply) <= CW'(v_th))
                   && (dirty_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (thr_hit)
                    state_nxt = ARMED;
                else if (scan_req)
                    state_nxt = SCAN;
            end
            ARMED: begin
                if (ckpt_ack)
                    state_nxt = SCAN;
            end
            SCAN: begin
                if (!ffs_valid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        irq_chkpnt = (state == ARMED);
        scan_valid = 1'b0;
        scan_idx   = '0;
        scan_done  = 1'b0;
        if (state == SCAN) begin
            scan_valid = ffs_valid;
            scan_idx   = ffs_idx;
            scan_done  = !ffs_valid;
        end
    end

endmodule

// File: tb/tb_dirty_block_tracker.sv
// Self-checking bench for dirty_block_tracker (default geometry, 16 blocks).
// Directed vector table, corner-case sequences, then random vs. a reference model.
module tb_dirty_block_tracker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] data_addr;
    logic        data_wr;
    logic [15:0] sp;
    logic [15:0] lambda;
    logic [31:0] v_supply;
    logic        ckpt_ack;
    logic        scan_req;
    logic        scan_pop;
    logic        irq_chkpnt;
    logic        scan_valid;
    logic [3:0]  scan_idx;
    logic        scan_done;
    logic [4:0]  dirty_cnt;
    logic [15:0] dirty_tbl;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dirty_block_tracker dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_addr  (data_addr),
        .data_wr    (data_wr),
        .sp         (sp),
        .lambda     (lambda),
        .v_supply   (v_supply),
        .ckpt_ack   (ckpt_ack),
        .scan_req   (scan_req),
        .scan_pop   (scan_pop),
        .irq_chkpnt (irq_chkpnt),
        .scan_valid (scan_valid),
        .scan_idx   (scan_idx),
        .scan_done  (scan_done),
        .dirty_cnt  (dirty_cnt),
        .dirty_tbl  (dirty_tbl)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] tbl;
        logic [4:0]  cnt;
    } vec_t;

    vec_t vt[6];

    // Reference model state.
    bit m_dirty[16];
    int m_cnt;
    int m_mode;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({irq_chkpnt, scan_valid, scan_idx, scan_done,
                    dirty_cnt, dirty_tbl});
    endfunction

    function automatic logic [15:0] baddr(input int b);
        return 16'(32'h0200 + b * 128);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        data_wr   = 1'b0;
        data_addr = 16'h0000;
        scan_req  = 1'b0;
        scan_pop  = 1'b0;
        ckpt_ack  = 1'b0;
        lambda    = 16'd1;
        v_supply  = 32'hFFFF_FFFF;
        sp        = 16'hFFFF;
    endtask

    task automatic do_reset();
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a);
        data_wr   = 1'b1;
        data_addr = a;
        tick();
        data_wr = 1'b0;
    endtask

    task automatic drain(input string name);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (scan_done) begin
                seen = 1;
                break;
            end
            scan_pop = 1'b1;
            tick();
        end
        scan_pop = 1'b0;
        chk(name, 32'(seen), 32'd1);
        tick();
    endtask

    task automatic model_step();
        bit nd[16];
        bit any;
        int low;
        int cnt;
        int sb;
        if (reset_n) begin
            foreach (m_dirty[b]) m_dirty[b] = 0;
            m_cnt  = 0;
            m_mode = 0;
            return;
        end
        any = 0;
        low = 0;
        cnt = 0;
        for (int b = 15; b >= 0; b--) begin
            if (m_dirty[b]) begin
                any = 1;
                low = b;
                cnt++;
            end
        end
        nd = m_dirty;
        if (m_mode == 2 && any && scan_pop) nd[low] = 0;
`ifdef DICA_STACK_FILTER_EN
        if (sp >= 16'h0200 && sp <= 16'h09FF) begin
            sb = (int'(sp) - 'h200) / 128;
            for (int b = 0; b < 16; b++)
                if (b > 8 && b < sb) nd[b] = 0;
        end
`else
        sb = 0;
`endif
        if (data_wr && data_addr >= 16'h0200 && data_addr <= 16'h09FF)
            nd[(int'(data_addr) - 'h200) / 128] = 1;
        case (m_mode)
            0: begin
                if (m_cnt != 0 &&
                    longint'(v_supply) <= longint'(lambda) * m_cnt)
                    m_mode = 1;
                else if (scan_req)
                    m_mode = 2;
            end
            1: if (ckpt_ack) m_mode = 2;
            default: if (!any) m_mode = 0;
        endcase
        m_cnt   = cnt;
        m_dirty = nd;
    endtask

    function automatic logic [31:0] model_outs();
        logic [15:0] t;
        bit any;
        int low;
        logic v;
        logic [3:0] ix;
        logic dn;
        t = '0;
        any = 0;
        low = 0;
        for (int b = 15; b >= 0; b--) begin
            t[b] = m_dirty[b];
            if (m_dirty[b]) begin
                any = 1;
                low = b;
            end
        end
        v  = (m_mode == 2) && any;
        ix = v ? 4'(low) : 4'd0;
        dn = (m_mode == 2) && !any;
        return 32'({(m_mode == 1), v, ix, dn, 5'(m_cnt), t});
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp5;
        logic [15:0] exp5w;
        int          seq3[4];
        reset_n = 1'b1;
        quiet();
        tick();
        chk("reset_outs", outs(), 32'd0);
        reset_n = 1'b0;

        // Marking: table lags write by one edge, count lags table by one.
        vt[0] = '{1'b1, 16'h0200, 16'h0001, 5'd0};
        vt[1] = '{1'b1, 16'h027E, 16'h0001, 5'd1};
        vt[2] = '{1'b1, 16'h0280, 16'h0003, 5'd1};
        vt[3] = '{1'b1, 16'h0A00, 16'h0003, 5'd2};
        vt[4] = '{1'b1, 16'h01FF, 16'h0003, 5'd2};
        vt[5] = '{1'b0, 16'h0300, 16'h0003, 5'd2};
        for (int i = 0; i < 6; i++) begin
            data_wr   = vt[i].wr;
            data_addr = vt[i].addr;
            tick();
            chk($sformatf("mark_tbl%0d", i), 32'(dirty_tbl), 32'(vt[i].tbl));
            chk($sformatf("mark_cnt%0d", i), 32'(dirty_cnt), 32'(vt[i].cnt));
            chk($sformatf("mark_irq%0d", i), 32'(irq_chkpnt), 32'd0);
        end
        quiet();

        // Threshold path.
        do_reset();
        wr(baddr(0));
        wr(baddr(1));
        wr(baddr(2));
        tick();
        chk("thr_cnt", 32'(dirty_cnt), 32'd3);
        lambda   = 16'd100;
        v_supply = 32'd400;
        tick();
        chk("thr_400_noirq", 32'(irq_chkpnt), 32'd0);
        v_supply = 32'd300;
        tick();
        chk("thr_300_irq", 32'(irq_chkpnt), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("thr_hold%0d", i), 32'(irq_chkpnt), 32'd1);
        end
        ckpt_ack = 1'b1;
        tick();
        ckpt_ack = 1'b0;
        v_supply = 32'hFFFF_FFFF;
        chk("thr_ack_irq", 32'(irq_chkpnt), 32'd0);
        chk("thr_ack_scan", 32'({scan_valid, scan_idx}), 32'h10);
        drain("thr_drain");

        // Scan of 16'h8421.
        do_reset();
        wr(baddr(0));
        wr(baddr(5));
        wr(baddr(10));
        wr(baddr(15));
        chk("scan_tbl", 32'(dirty_tbl), 32'h8421);
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        chk("scan_noirq", 32'(irq_chkpnt), 32'd0);
        seq3 = '{0, 5, 10, 15};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("scan_pop%0d", k), 32'({scan_valid, scan_idx}),
                32'(16 + seq3[k]));
            scan_pop = 1'b1;
            tick();
            scan_pop = 1'b0;
        end
        chk("scan_done_hi", 32'(scan_done), 32'd1);
        tick();
        chk("scan_done_lo", 32'({scan_done, scan_valid}), 32'd0);
        chk("scan_cnt0", 32'(dirty_cnt), 32'd0);

        // Same-cycle pop and write on block 5.
        do_reset();
        wr(baddr(3));
        wr(baddr(5));
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        chk("wp_idx3", 32'(scan_idx), 32'd3);
        scan_pop = 1'b1;
        tick();
        chk("wp_idx5", 32'({scan_valid, scan_idx}), 32'h15);
        data_wr   = 1'b1;
        data_addr = 16'h04A0;
        tick();
        data_wr  = 1'b0;
        scan_pop = 1'b0;
        chk("wp_keep5", 32'({scan_valid, scan_idx}), 32'h15);
        chk("wp_tbl", 32'(dirty_tbl), 32'h0020);
        drain("wp_drain");

        // Dead-stack filter.
        do_reset();
        for (int b = 8; b <= 13; b++) wr(baddr(b));
        tick();
        chk("filt_pre", 32'(dirty_tbl), 32'h3F00);
        sp = 16'h0880;
        tick();
`ifdef DICA_STACK_FILTER_EN
        exp5  = 16'h2100;
        exp5w = 16'h2500;
`else
        exp5  = 16'h3F00;
        exp5w = 16'h3F00;
`endif
        chk("filt_clear", 32'(dirty_tbl), 32'(exp5));
        wr(baddr(10));
        chk("filt_wr_exempt", 32'(dirty_tbl), 32'(exp5w));
        sp = 16'hFFFF;
        tick();
        chk("filt_sp_out", 32'(dirty_tbl), 32'(exp5w));

        // Reset during ARMED.
        do_reset();
        for (int b = 0; b < 4; b++) wr(baddr(b));
        tick();
        lambda   = 16'd100;
        v_supply = 32'd0;
        tick();
        chk("rst_armed", 32'(irq_chkpnt), 32'd1);
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
        chk("rst_outs", outs(), 32'd0);
        tick();
        chk("rst_after", outs(), 32'd0);
        quiet();

        // Random traffic against the reference model.
        do_reset();
        reset_n = 1'b1;
        model_step();
        reset_n = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset_n   = ($urandom_range(0, 99) == 0);
            data_wr   = 1'($urandom_range(0, 1));
            data_addr = ($urandom_range(0, 9) < 7)
                      ? 16'(32'h0200 + $urandom_range(0, 2047))
                      : 16'($urandom);
            sp        = ($urandom_range(0, 1) == 1)
                      ? 16'(32'h0200 + $urandom_range(0, 2047))
                      : 16'hFFFF;
            lambda    = 16'($urandom_range(0, 300));
            v_supply  = $urandom_range(0, 3000);
            ckpt_ack  = ($urandom_range(0, 3) == 0);
            scan_req  = ($urandom_range(0, 7) == 0);
            scan_pop  = 1'($urandom_range(0, 1));
            model_step();
            tick();
            chk($sformatf("rand%0d", c), outs(), model_outs());
        end
        reset_n = 1'b0;
        quiet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
